// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the shift-add multiplier sequencer.
// Holds the FSM state encoding, the ALU control opcodes and the iteration count.
package mul_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_e;

  localparam logic [3:0] ALU_OP_AND = 4'b0000;
  localparam logic [3:0] ALU_OP_OR  = 4'b0001;
  localparam logic [3:0] ALU_OP_ADD = 4'b0010;
  localparam logic [3:0] ALU_OP_SUB = 4'b0110;

  localparam int MUL_ITER = 32;

endpackage

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle shift-add multiplier sequencer; borrows the EX-stage ALU in ADD mode.
// Optional MUL_ZERO_BYPASS_EN: a zero operand skips RUN and completes in one cycle.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            hi_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [XLEN-1:0] alu_in1_o,
  output logic [XLEN-1:0] alu_in2_o,
  output logic [3:0]      alu_ctrl_o,
  input  logic [XLEN-1:0] alu_res_i,
  input  logic            alu_carry_i
);

  mul_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] acc_hi;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] mcand;
  logic            hi_q;

  // Next {acc_hi, mplier} after this iteration: ALU sum with carry, shifted right by one.
  logic [XLEN-1:0] acc_nxt;
  logic [XLEN-1:0] mplier_nxt;
  logic            last_iter;
  logic            zero_op;

  assign acc_nxt    = {alu_carry_i, alu_res_i[XLEN-1:1]};
  assign mplier_nxt = {alu_res_i[0], mplier[XLEN-1:1]};
  assign last_iter  = (cnt == CNT_W'(MUL_ITER - 1));
  assign zero_op    = (op1_i == '0) || (op2_i == '0);

  assign ready_o    = (state == IDLE);
  assign busy_o     = (state != IDLE);
  assign alu_in1_o  = acc_hi;
  assign alu_in2_o  = mplier[0] ? mcand : '0;
  assign alu_ctrl_o = (state == RUN) ? ALU_OP_ADD : ALU_OP_AND;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      mplier   <= '0;
      mcand    <= '0;
      hi_q     <= 1'b0;
      result_o <= '0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          // flush outranks start; only a clean accept loads the operands
          if (start_i && !flush_i) begin
            mcand  <= op1_i;
            mplier <= op2_i;
            acc_hi <= '0;
            hi_q   <= hi_i;
            cnt    <= '0;
`ifdef MUL_ZERO_BYPASS_EN
            if (zero_op) begin
              state    <= DONE;
              result_o <= '0;
              done_o   <= 1'b1;
            end else begin
              state <= RUN;
            end
`else
            state <= RUN;
`endif
          end
        end
        RUN: begin
          if (flush_i) begin
            state <= IDLE;
          end else begin
            acc_hi <= acc_nxt;
            mplier <= mplier_nxt;
            cnt    <= cnt + 1'b1;
            if (last_iter) begin
              state    <= DONE;
              done_o   <= 1'b1;
              result_o <= hi_q ? acc_nxt : mplier_nxt;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifndef MUL_ZERO_BYPASS_EN
  logic unused_zero;
  assign unused_zero = zero_op;
`endif

endmodule
